// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, sequencer state encoding
// and the memory-icode classifier.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_PCUPD  = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_PCUPD  = ST_PCUPD,
    S_HALT   = ST_HALT
  } seq_state_e;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: is_mem_icode = 1'b1;
      default:                                            is_mem_icode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer and PC register for the Y86-64 core.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt / retired_cnt performance counters.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MEM_TMO  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              dmem_ready,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              mem_req,
  output logic [2:0]        stat,
  output logic              busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);

  localparam int            CW       = $clog2(MEM_TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TMO - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(MEM_TMO);

  seq_state_e        state_reg, state_next;
  logic [2:0]        stat_reg, stat_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [CW-1:0]     tmo_cnt_reg;
  logic              mem_op;

  assign mem_op = is_mem_icode(icode);

  always_comb begin
    state_next = state_reg;
    stat_next  = stat_reg;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    exec_en    = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    mem_req    = 1'b0;
    busy       = (state_reg != S_IDLE) && (state_reg != S_HALT);
    unique case (state_reg)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH: begin
        fetch_en   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        decode_en = 1'b1;
        if (imem_error) begin
          stat_next  = STAT_ADR;
          state_next = S_HALT;
        end else if (!instr_valid) begin
          stat_next  = STAT_INS;
          state_next = S_HALT;
        end else if (icode == I_HALT) begin
          stat_next  = STAT_HLT;
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en    = 1'b1;
        state_next = S_MEM;
      end
      S_MEM: begin
        mem_en = 1'b1;
        // The counter is zero only on the entry cycle, which is where the request pulses.
        mem_req = mem_op && (tmo_cnt_reg == '0);
        if (!mem_op) begin
          state_next = S_WB;
        end else if (dmem_ready) begin
          if (dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_HALT;
          end else begin
            state_next = S_WB;
          end
        end else if (tmo_cnt_reg >= TMO_LAST) begin
          stat_next  = STAT_ADR;
          state_next = S_HALT;
        end
      end
      S_WB: begin
        wb_en      = 1'b1;
        state_next = S_PCUPD;
      end
      S_PCUPD:  state_next = run ? S_FETCH : S_IDLE;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      stat_reg    <= STAT_AOK;
      pc_reg      <= RESET_PC;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      stat_reg  <= stat_next;
      if (state_reg == S_PCUPD) pc_reg <= next_pc;
      // Held at zero outside MEM so every MEM visit starts counting from the entry cycle.
      if (state_reg != S_MEM)          tmo_cnt_reg <= '0;
      else if (tmo_cnt_reg != TMO_MAX) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign pc   = pc_reg;
  assign stat = stat_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg, retired_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= '0;
      retired_cnt_reg <= '0;
    end else begin
      if (busy)                cycle_cnt_reg   <= cycle_cnt_reg + 32'd1;
      if (state_reg == S_PCUPD) retired_cnt_reg <= retired_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign retired_cnt = retired_cnt_reg;
`endif

endmodule
